// File: rtl/game_pkg.sv
// Shared types and frame constants for the sand simulation.
// Used by the update engine, the frame copy and the RAM write arbiter.
package game_pkg;

  localparam int GAME_COLUMNS = 640;
  localparam int GAME_ROWS    = 480;
  localparam int FRAME_CELLS  = GAME_COLUMNS * GAME_ROWS;

  typedef enum logic [1:0] {
    IDLE,
    SIM_OWN,
    USR_OWN
  } arb_state_t;

endpackage

// File: rtl/ram_wr_arbiter_wr_port_reg.sv
// Registered RAM write stage: picks the accepted beat,
// range checks its address and drives the write strobe.
module wr_port_reg
  import game_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 1,
  parameter int CELLS      = FRAME_CELLS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sim_acc_i,
  input  logic                  usr_acc_i,
  input  logic [ADDR_WIDTH-1:0] sim_addr_i,
  input  logic [DATA_WIDTH-1:0] sim_data_i,
  input  logic [ADDR_WIDTH-1:0] usr_addr_i,
  input  logic [DATA_WIDTH-1:0] usr_data_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_en_o,
  output logic                  addr_err_o
);

  localparam logic [ADDR_WIDTH:0] LP_LIMIT =
    (ADDR_WIDTH+1)'(CELLS);

  logic                  w_acc;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic                  r_err;

  // grants are one-hot, so at most one accept is live
  assign w_acc      = sim_acc_i | usr_acc_i;
  assign w_addr     = usr_acc_i ? usr_addr_i : sim_addr_i;
  assign w_data     = usr_acc_i ? usr_data_i : sim_data_i;
  assign w_in_range = {1'b0, w_addr} < LP_LIMIT;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_addr <= '0;
      r_data <= '0;
      r_en   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_en  <= w_acc & w_in_range;
      r_err <= w_acc & ~w_in_range;
      if (w_acc) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign ram_addr_o = r_addr;
  assign ram_data_o = r_data;
  assign ram_en_o   = r_en;
  assign addr_err_o = r_err;

endmodule

// File: rtl/ram_wr_arbiter.sv
// Burst arbiter for the simulation RAM write port:
// SIM has priority, USR is protected by a starvation limit.
module ram_wr_arbiter
  import game_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = GAME_COLUMNS,
  parameter int ACTIVE_ROWS    = GAME_ROWS,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int MAX_WAIT       = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sim_req_i,
  input  logic                  sim_last_i,
  input  logic [ADDR_WIDTH-1:0] sim_wr_address_i,
  input  logic [DATA_WIDTH-1:0] sim_wr_data_i,
  output logic                  sim_gnt_o,
  input  logic                  usr_req_i,
  input  logic                  usr_last_i,
  input  logic [ADDR_WIDTH-1:0] usr_wr_address_i,
  input  logic [DATA_WIDTH-1:0] usr_wr_data_i,
  output logic                  usr_gnt_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic                  addr_err_o
);

  localparam int WW = $clog2(MAX_WAIT+1);
  localparam logic [WW-1:0] LP_MAX = WW'(MAX_WAIT);

  arb_state_t    r_state;
  logic [WW-1:0] r_wait_cnt;

  logic w_sim_acc;
  logic w_usr_acc;
  logic w_starved;

  assign sim_gnt_o = (r_state == SIM_OWN);
  assign usr_gnt_o = (r_state == USR_OWN);
  assign w_sim_acc = sim_req_i & sim_gnt_o;
  assign w_usr_acc = usr_req_i & usr_gnt_o;
  assign w_starved = usr_req_i & (r_wait_cnt == LP_MAX);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      if (!usr_req_i || r_state == USR_OWN)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != LP_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;

      unique case (r_state)
        IDLE: begin
          if (sim_req_i)      r_state <= SIM_OWN;
          else if (usr_req_i) r_state <= USR_OWN;
        end
        SIM_OWN: begin
          // preemption leaves SIM parked mid-burst until re-granted
          if (w_starved)
            r_state <= USR_OWN;
          else if (w_sim_acc && sim_last_i) begin
            if (usr_req_i)      r_state <= USR_OWN;
            else if (sim_req_i) r_state <= SIM_OWN;
            else                r_state <= IDLE;
          end
        end
        USR_OWN: begin
          if (w_usr_acc && usr_last_i) begin
            if (sim_req_i)      r_state <= SIM_OWN;
            else if (usr_req_i) r_state <= USR_OWN;
            else                r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  wr_port_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CELLS      (ACTIVE_COLUMNS*ACTIVE_ROWS)
  ) u_wr_port (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .sim_acc_i  (w_sim_acc),
    .usr_acc_i  (w_usr_acc),
    .sim_addr_i (sim_wr_address_i),
    .sim_data_i (sim_wr_data_i),
    .usr_addr_i (usr_wr_address_i),
    .usr_data_i (usr_wr_data_i),
    .ram_addr_o (ram_wr_address_o),
    .ram_data_o (ram_wr_data_o),
    .ram_en_o   (ram_wr_en_o),
    .addr_err_o (addr_err_o)
  );

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Directed bench for ram_wr_arbiter with a short starvation limit.
// Expected values are hand-derived per cycle.
module tb_ram_wr_arbiter;

  localparam int AW = $clog2(640*480);
  localparam int DW = 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          sim_req_i = 1'b0;
  logic          sim_last_i = 1'b0;
  logic [AW-1:0] sim_wr_address_i = '0;
  logic [DW-1:0] sim_wr_data_i = '0;
  logic          sim_gnt_o;
  logic          usr_req_i = 1'b0;
  logic          usr_last_i = 1'b0;
  logic [AW-1:0] usr_wr_address_i = '0;
  logic [DW-1:0] usr_wr_data_i = '0;
  logic          usr_gnt_o;
  logic [AW-1:0] ram_wr_address_o;
  logic [DW-1:0] ram_wr_data_o;
  logic          ram_wr_en_o;
  logic          addr_err_o;

  int n_vec = 0;
  int n_err = 0;

  ram_wr_arbiter #(
    .ACTIVE_COLUMNS (640),
    .ACTIVE_ROWS    (480),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_WAIT       (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .sim_req_i        (sim_req_i),
    .sim_last_i       (sim_last_i),
    .sim_wr_address_i (sim_wr_address_i),
    .sim_wr_data_i    (sim_wr_data_i),
    .sim_gnt_o        (sim_gnt_o),
    .usr_req_i        (usr_req_i),
    .usr_last_i       (usr_last_i),
    .usr_wr_address_i (usr_wr_address_i),
    .usr_wr_data_i    (usr_wr_data_i),
    .usr_gnt_o        (usr_gnt_o),
    .ram_wr_address_o (ram_wr_address_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_wr_en_o      (ram_wr_en_o),
    .addr_err_o       (addr_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_reset();
    sim_req_i  = 1'b0;
    usr_req_i  = 1'b0;
    sim_last_i = 1'b0;
    usr_last_i = 1'b0;
    reset_i    = 1'b0;
    tick();
    reset_i = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input int a, input int d);
    chk({tag, "_en"}, 32'(ram_wr_en_o), 1);
    chk({tag, "_addr"}, 32'(ram_wr_address_o), 32'(a));
    chk({tag, "_data"}, 32'(ram_wr_data_o), 32'(d));
  endtask

  initial begin
    // reset held with both requests high
    sim_req_i = 1'b1;
    usr_req_i = 1'b1;
    sim_wr_address_i = AW'(3);
    usr_wr_address_i = AW'(4);
    repeat (3) tick();
    chk("rst_sim_gnt", 32'(sim_gnt_o), 0);
    chk("rst_usr_gnt", 32'(usr_gnt_o), 0);
    chk("rst_en", 32'(ram_wr_en_o), 0);
    chk("rst_err", 32'(addr_err_o), 0);
    chk("rst_addr", 32'(ram_wr_address_o), 0);
    chk("rst_data", 32'(ram_wr_data_o), 0);
    reset_i = 1'b1;
    tick();
    chk("rel_sim_gnt", 32'(sim_gnt_o), 1);
    chk("rel_usr_gnt", 32'(usr_gnt_o), 0);
    chk("rel_no_wr", 32'(ram_wr_en_o), 0);
    idle_reset();

    // SIM burst of four beats, addresses 10..13
    sim_req_i = 1'b1;
    sim_wr_data_i = 1'b1;
    sim_wr_address_i = AW'(10);
    tick();
    chk("b_gnt", 32'(sim_gnt_o), 1);
    chk("b_idle_no_wr", 32'(ram_wr_en_o), 0);
    for (int i = 0; i < 4; i++) begin
      sim_wr_address_i = AW'(10 + i);
      sim_last_i = (i == 3);
      tick();
      chk_wr("b_beat", 10 + i, 1);
    end
    sim_req_i = 1'b0;
    sim_last_i = 1'b0;
    tick();
    chk("b_after_en", 32'(ram_wr_en_o), 0);
    chk("b_after_addr_hold", 32'(ram_wr_address_o), 13);
    chk("b_after_usr_gnt", 32'(usr_gnt_o), 0);
    idle_reset();

    // starvation preemption with MAX_WAIT=4
    sim_req_i = 1'b1;
    sim_last_i = 1'b0;
    sim_wr_address_i = AW'(100);
    sim_wr_data_i = 1'b0;
    tick();
    chk("p_sim_gnt", 32'(sim_gnt_o), 1);
    usr_req_i = 1'b1;
    usr_last_i = 1'b0;
    usr_wr_address_i = AW'(200);
    usr_wr_data_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p_wait_usr_gnt", 32'(usr_gnt_o), 0);
      chk_wr("p_sim_beat", 100, 0);
    end
    tick();
    chk("p_pre_usr_gnt", 32'(usr_gnt_o), 1);
    chk("p_pre_sim_gnt", 32'(sim_gnt_o), 0);
    chk_wr("p_last_sim_beat", 100, 0);
    tick();
    chk_wr("p_usr0", 200, 1);
    usr_wr_address_i = AW'(201);
    usr_last_i = 1'b1;
    tick();
    chk_wr("p_usr1", 201, 1);
    chk("p_back_sim_gnt", 32'(sim_gnt_o), 1);
    chk("p_back_usr_gnt", 32'(usr_gnt_o), 0);
    usr_req_i = 1'b0;
    usr_last_i = 1'b0;
    tick();
    chk_wr("p_sim_resume", 100, 0);
    idle_reset();

    // alternating bursts, both pending
    sim_req_i = 1'b1;
    usr_req_i = 1'b1;
    sim_wr_data_i = 1'b0;
    usr_wr_data_i = 1'b1;
    sim_wr_address_i = AW'(300);
    usr_wr_address_i = AW'(400);
    tick();
    chk("a_sim_gnt0", 32'(sim_gnt_o), 1);
    tick();
    chk_wr("a_sim300", 300, 0);
    sim_wr_address_i = AW'(301);
    sim_last_i = 1'b1;
    tick();
    chk_wr("a_sim301", 301, 0);
    chk("a_usr_gnt", 32'(usr_gnt_o), 1);
    tick();
    chk_wr("a_usr400", 400, 1);
    usr_wr_address_i = AW'(401);
    usr_last_i = 1'b1;
    tick();
    chk_wr("a_usr401", 401, 1);
    chk("a_sim_gnt1", 32'(sim_gnt_o), 1);
    chk("a_usr_gnt1", 32'(usr_gnt_o), 0);
    sim_wr_address_i = AW'(302);
    usr_req_i = 1'b0;
    tick();
    chk_wr("a_sim302", 302, 0);
    idle_reset();

    // out-of-range USR beat
    usr_req_i = 1'b1;
    usr_last_i = 1'b0;
    usr_wr_data_i = 1'b1;
    usr_wr_address_i = AW'(5);
    tick();
    chk("r_usr_gnt", 32'(usr_gnt_o), 1);
    tick();
    chk_wr("r_beat5", 5, 1);
    chk("r_err0", 32'(addr_err_o), 0);
    usr_wr_address_i = AW'(307200);
    tick();
    chk("r_oob_en", 32'(ram_wr_en_o), 0);
    chk("r_oob_err", 32'(addr_err_o), 1);
    chk("r_oob_addr", 32'(ram_wr_address_o), 307200);
    usr_wr_address_i = AW'(6);
    usr_last_i = 1'b1;
    tick();
    chk_wr("r_beat6", 6, 1);
    chk("r_err_gone", 32'(addr_err_o), 0);
    chk("r_usr_keep", 32'(usr_gnt_o), 1);

    // USR drops req mid-burst while SIM waits
    usr_req_i = 1'b0;
    usr_last_i = 1'b0;
    sim_req_i = 1'b1;
    sim_wr_address_i = AW'(50);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d_usr_gnt", 32'(usr_gnt_o), 1);
      chk("d_sim_gnt", 32'(sim_gnt_o), 0);
      chk("d_no_wr", 32'(ram_wr_en_o), 0);
    end
    chk("d_addr_hold", 32'(ram_wr_address_o), 6);
    usr_req_i = 1'b1;
    usr_last_i = 1'b1;
    usr_wr_address_i = AW'(7);
    tick();
    chk_wr("d_beat7", 7, 1);
    chk("d_rel_sim_gnt", 32'(sim_gnt_o), 1);
    chk("d_rel_usr_gnt", 32'(usr_gnt_o), 0);

    // reset mid-burst issues no write
    usr_req_i = 1'b0;
    reset_i = 1'b0;
    tick();
    chk("m_rst_en", 32'(ram_wr_en_o), 0);
    chk("m_rst_gnt", 32'(sim_gnt_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
